// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter and its clients.
package cdb_arbiter_pkg;

    // Functional-unit requester indices on the CDB.
    localparam int FU_ALU   = 0;
    localparam int FU_BRALU = 1;
    localparam int FU_MUL   = 2;
    localparam int FU_DIV   = 3;
    localparam int FU_MEM   = 4;

    // Default machine sizing.
    localparam int FU_COUNT     = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ROB_IX_W = 3;

endpackage

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Rotating-priority picker: first set request at or above ptr, wrapping to 0.
// Purely combinational; the pointer state lives in the caller.
module rr_priority_picker #(
    parameter int N  = 5,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    // Walk offsets 0..N-1 from ptr; the first hit wins and later hits are ignored.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so a single conditional subtract is a full modulo.
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N))
                sum = sum - (PW+1)'(N);
            cand = sum[PW-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selects one completed FU result per
// cycle and broadcasts it one cycle later to the ROB / register file.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_FU     = FU_COUNT,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ROB_IX_W = DEF_ROB_IX_W
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [N_FU-1:0]                    fu_valid_in,
    input  logic [N_FU-1:0][DATA_W-1:0]        fu_data_in,
    input  logic [N_FU-1:0][ROB_IX_W-1:0]      fu_rob_idx_in,
    output logic [N_FU-1:0]                    fu_read_out,
    input  logic                               rob_ready_in,
    input  logic                               flush_in,
    output logic                               cdb_valid_out,
    output logic [DATA_W-1:0]                  cdb_data_out,
    output logic [ROB_IX_W-1:0]                cdb_rob_idx_out,
    output logic [$clog2(N_FU)-1:0]            cdb_src_out
);

    localparam int PW = $clog2(N_FU);

    logic [PW-1:0]   rr_ptr;
    logic            arb_en;
    logic [N_FU-1:0] req_eff;
    logic [N_FU-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;

    // Reset, flush and a stalled ROB all suppress the grant in the same cycle,
    // so an FU is never told its result was consumed when it was not.
    always_comb begin
        arb_en  = rob_ready_in & ~flush_in & ~rst_in;
        req_eff = fu_valid_in & {N_FU{arb_en}};
    end

    rr_priority_picker #(
        .N  (N_FU),
        .PW (PW)
    ) u_picker (
        .req   (req_eff),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign fu_read_out = grant;

    // Register the winner onto the bus and advance the pointer past it;
    // idle cycles drop valid but keep the last payload on the bus.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr          <= '0;
            cdb_valid_out   <= 1'b0;
            cdb_data_out    <= '0;
            cdb_rob_idx_out <= '0;
            cdb_src_out     <= '0;
        end else if (grant_any) begin
            rr_ptr          <= (grant_idx == PW'(N_FU-1)) ? '0 : grant_idx + 1'b1;
            cdb_valid_out   <= 1'b1;
            cdb_data_out    <= fu_data_in[grant_idx];
            cdb_rob_idx_out <= fu_rob_idx_in[grant_idx];
            cdb_src_out     <= grant_idx;
        end else begin
            cdb_valid_out   <= 1'b0;
        end
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_FU, default 5, number of functional-unit requesters (index 0 alu, 1 brAlu, 2 mul, 3 div, 4 mem).
REQ-002 Parameter DATA_W, default 32, result width.
REQ-003 Parameter ROB_IX_W, default 3, ROB index width.
REQ-004 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 fu_valid_in  input  N_FU  requester i holds a completed result.
REQ-007 fu_data_in  input  N_FU x DATA_W  per-requester result, signed.
REQ-008 fu_rob_idx_in  input  N_FU x ROB_IX_W  per-requester destination ROB index.
REQ-009 fu_read_out  output  N_FU  one-hot grant; drives the FU read_in, consumes that result this cycle.
REQ-010 rob_ready_in  input  1  ROB/register file can accept a broadcast this cycle.
REQ-011 flush_in  input  1  pipeline flush; in-flight results are discarded.
REQ-012 cdb_valid_out  output  1  broadcast valid.
REQ-013 cdb_data_out  output  DATA_W  broadcast result.
REQ-014 cdb_rob_idx_out  output  ROB_IX_W  broadcast ROB index.
REQ-015 cdb_src_out  output  $clog2(N_FU)  index of the FU that won.

Function
REQ-016 fu_read_out is combinational from fu_valid_in, rr_ptr, rob_ready_in and flush_in; at most one bit set.
REQ-017 Grant goes to the first set fu_valid_in bit searching from rr_ptr upward, wrapping N_FU-1 -> 0.
REQ-018 No grant while rob_ready_in=0 or flush_in=1, or when fu_valid_in=0.
REQ-019 On grant to i: next edge registers cdb_valid_out=1, cdb_data_out=fu_data_in[i], cdb_rob_idx_out=fu_rob_idx_in[i], cdb_src_out=i; latency exactly 1 cycle, one result per cycle max.
REQ-020 On grant to i: rr_ptr <= (i+1) mod N_FU; without a grant rr_ptr holds.
REQ-021 Cycle without a grant: cdb_valid_out <= 0; data, rob_idx, src hold their last values.
REQ-022 flush_in=1: cdb_valid_out <= 0 next edge and no grant that cycle; a broadcast already registered is still visible in the flush cycle; flush takes precedence over rob_ready_in.
REQ-023 A requester not granted keeps fu_valid_in high and data stable (FU holds until read); the arbiter never drops an ungranted request.
REQ-024 Fairness: with all N_FU requesting continuously and rob_ready_in=1, each FU is granted exactly once per N_FU consecutive cycles.
REQ-025 Single requester stays granted every cycle it asserts valid (no idle bubbles).
REQ-026 Reset asserted mid-operation overrides grant and flush in that cycle; fu_read_out forced to 0 while rst_in=1.

Reset
REQ-027 On rst_in at an edge: rr_ptr=0, cdb_valid_out=0, cdb_data_out=0, cdb_rob_idx_out=0, cdb_src_out=0.
REQ-028 fu_read_out=0 during any cycle rst_in=1.
REQ-029 First cycle after reset release: priority order 0,1,...,N_FU-1.

Structure
REQ-030 FU index constants (FU_ALU=0 ... FU_MEM=4), N_FU, ROB_IX_W live in the shared types.svh package; top_level and reservation stations use the same constants.
REQ-031 One combinational sub-module rr_priority_picker (request vector + pointer -> one-hot grant + encoded index); all state stays in cdb_arbiter.
REQ-032 top_level instantiates cdb_arbiter, connects fu_read_out[FU_ALU] to the alu read_in, and routes cdb outputs to the register file write port and reservation-station tag match.

Verification
REQ-033 Reset, then fu_valid_in=5'b00001, data 32'd7, rob 3 -> fu_read_out=00001 same cycle; next cycle cdb_valid_out=1, data 7, rob 3, src 0.
REQ-034 fu_valid_in=5'b11111 held 10 cycles, rob_ready_in=1 -> grants 0,1,2,3,4,0,1,2,3,4; cdb_valid_out high all 10 following cycles.
REQ-035 rr_ptr=4 state, fu_valid_in=5'b10001 -> grant 4 then 0 (wrap-around).
REQ-036 fu_valid_in=5'b00100, rob_ready_in=0 for 3 cycles then 1 -> no grant for 3 cycles, cdb_valid_out=0, then grant 2 and broadcast next cycle.
REQ-037 Broadcast registered, flush_in=1 with fu_valid_in=5'b00010 -> no grant that cycle, cdb_valid_out=0 next cycle, rr_ptr unchanged.
REQ-038 rst_in=1 while fu_valid_in=5'b11111 -> fu_read_out=0; after release first grant is FU 0.
